// File: rtl/store_buffer_pkg.sv
// Shared widths and the store-entry record for the store buffer slice.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 16;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the occupied window of the circular store buffer.
module sb_match #(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = 16,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addrs [DEPTH],
  input  logic [IW-1:0]     head,
  input  logic [IW:0]       count,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [IW-1:0]     idx
);

  logic [IW-1:0] pos;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + IW'(k);
      if (((IW+1)'(k) < count) && (addrs[pos] == ld_addr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM-stage issue logic and single-port data memory.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              St_Valid,
  input  logic [ADDR_W-1:0] St_Addr,
  input  logic [DATA_W-1:0] St_Data,
  output logic              St_Ready,
  input  logic              Ld_Req,
  input  logic [ADDR_W-1:0] Ld_Addr,
  output logic [DATA_W-1:0] Ld_Data,
  output logic              Ld_Stall,
  output logic              Empty,
  output logic [ADDR_W-1:0] Address,
  output logic              Mem_Write,
  output logic              Mem_Read,
  output logic [DATA_W-1:0] DM_WData,
  input  logic [DATA_W-1:0] DM_RData
);

  localparam int IW = $clog2(DEPTH);

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [IW-1:0]     head, tail;
  logic [IW:0]       count;

  logic          full, hit, ld_miss, ld_port, drain, enq;
  logic [IW-1:0] hit_idx;

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .addrs   (ent_addr),
    .head    (head),
    .count   (count),
    .ld_addr (Ld_Addr),
    .hit     (hit),
    .idx     (hit_idx)
  );

  // A drain is suppressed in a reset cycle so the entry being discarded never reaches DM.
  always_comb begin
    full     = (count == (IW+1)'(DEPTH));
    ld_miss  = Ld_Req && !hit;
    ld_port  = ld_miss && !full;
    drain    = Reset_n && (count != '0) && !ld_port;
    enq      = St_Valid && !full;

    St_Ready  = !full;
    Empty     = (count == '0);
    Ld_Stall  = ld_miss && full;
    Mem_Read  = ld_port;
    Mem_Write = drain;
    Address   = '0;
    DM_WData  = '0;
    Ld_Data   = '0;

    if (ld_port) begin
      Address = Ld_Addr;
      Ld_Data = DM_RData;
    end else if (drain) begin
      Address  = ent_addr[head];
      DM_WData = ent_data[head];
    end
    if (Ld_Req && hit) Ld_Data = ent_data[hit_idx];
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        ent_addr[tail] <= St_Addr;
        ent_data[tail] <= St_Data;
        tail           <= tail + IW'(1);
      end
      if (drain) head <= head + IW'(1);
      if (enq && !drain)      count <= count + (IW+1)'(1);
      else if (!enq && drain) count <= count - (IW+1)'(1);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue-based reference model plus a DM model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset_n, St_Valid, St_Ready, Ld_Req, Ld_Stall, Empty, Mem_Write, Mem_Read;
  logic [15:0] St_Addr, St_Data, Ld_Addr, Ld_Data, Address, DM_WData, DM_RData;

  logic [15:0] dm  [0:65535];
  logic [15:0] rdm [0:65535];

  typedef struct {
    logic        st_ready, empty, ld_stall, mem_write, mem_read;
    logic [15:0] ld_data, address, wdata;
  } exp_t;

  exp_t      expq [$];
  sb_entry_t q    [$];
  int        total = 0;
  int        bad   = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .St_Valid(St_Valid), .St_Addr(St_Addr),
    .St_Data(St_Data), .St_Ready(St_Ready), .Ld_Req(Ld_Req), .Ld_Addr(Ld_Addr),
    .Ld_Data(Ld_Data), .Ld_Stall(Ld_Stall), .Empty(Empty), .Address(Address),
    .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .DM_WData(DM_WData), .DM_RData(DM_RData)
  );

  always #5 CLK = ~CLK;

  assign DM_RData = dm[Address];
  always @(posedge CLK) if (Mem_Write === 1'b1) dm[Address] <= DM_WData;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("st_ready",  {15'd0, St_Ready},  {15'd0, e.st_ready});
      chk("empty",     {15'd0, Empty},     {15'd0, e.empty});
      chk("ld_stall",  {15'd0, Ld_Stall},  {15'd0, e.ld_stall});
      chk("mem_write", {15'd0, Mem_Write}, {15'd0, e.mem_write});
      chk("mem_read",  {15'd0, Mem_Read},  {15'd0, e.mem_read});
      chk("ld_data",   Ld_Data,  e.ld_data);
      chk("address",   Address,  e.address);
      chk("dm_wdata",  DM_WData, e.wdata);
    end
  end

  task automatic cycle(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lr, input logic [15:0] la, input logic rn);
    exp_t        e;
    sb_entry_t   ent;
    int          n;
    logic        hit, full, miss, lport, drn;
    logic [15:0] hd;
    @(posedge CLK);
    #1;
    St_Valid = sv; St_Addr = sa; St_Data = sd;
    Ld_Req = lr; Ld_Addr = la; Reset_n = rn;
    n    = q.size();
    full = (n == DEPTH);
    hit  = 1'b0;
    hd   = '0;
    for (int i = n - 1; i >= 0; i--)
      if (!hit && q[i].addr == la) begin
        hit = 1'b1;
        hd  = q[i].data;
      end
    miss  = lr && !hit;
    lport = miss && !full;
    drn   = rn && (n > 0) && !lport;
    e.st_ready  = !full;
    e.empty     = (n == 0);
    e.ld_stall  = miss && full;
    e.mem_read  = lport;
    e.mem_write = drn;
    e.ld_data   = !lr ? 16'h0 : hit ? hd : lport ? rdm[la] : 16'h0;
    e.address   = lport ? la : drn ? q[0].addr : 16'h0;
    e.wdata     = drn ? q[0].data : 16'h0;
    expq.push_back(e);
    if (!rn) begin
      q.delete();
    end else begin
      if (drn) begin
        rdm[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end
      if (sv && !full) begin
        ent.addr = sa;
        ent.data = sd;
        q.push_back(ent);
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dm[i]  = 16'hD000 ^ 16'(i);
      rdm[i] = 16'hD000 ^ 16'(i);
    end
    dm[2]  = 16'h00FF;
    rdm[2] = 16'h00FF;
    St_Valid = 1'b0; St_Addr = '0; St_Data = '0;
    Ld_Req = 1'b0; Ld_Addr = '0; Reset_n = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 Reset_n = 1'b1;

    repeat (3) idle();

    cycle(1'b1, 16'd3, 16'h1234, 1'b0, 16'h0, 1'b1);
    repeat (2) idle();

    // Load misses hold the port, so the buffer fills and then force-drains.
    for (int i = 0; i < 10; i++)
      cycle(i < 4, 16'(8 + i), 16'(16'h0100 + i), 1'b1, 16'h0, 1'b1);
    repeat (6) idle();

    cycle(1'b1, 16'd5, 16'h0AAA, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'd5, 16'h0BBB, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'd5, 1'b1);
    repeat (4) idle();

    cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'd2, 1'b1);

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'(12 + i), 16'(16'h0C00 + i), 1'b1, 16'h0, 1'b1);
    idle();
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    repeat (3) idle();

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 1) == 1), 16'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 2) == 0), 16'($urandom_range(0, 7)),
            ($urandom_range(0, 49) != 0));

    repeat (8) idle();
    @(negedge CLK);
    @(posedge CLK);
    #1;
    for (int a = 0; a < 16; a++) chk($sformatf("dm[%0d]", a), dm[a], rdm[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
